// File: rtl/i2c_reg_target_if.sv
// rtl/i2c_reg_target_if.sv - I2C pad-side signals between controller and register target
interface i2c_reg_target_if;
    logic scl_i;
    logic sda_i;
    logic sda_oe;

    modport master (output scl_i, output sda_i, input sda_oe);
    modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/i2c_reg_target.sv
// rtl/i2c_reg_target.sv - I2C target exposing NREGS 8-bit registers with auto-increment read/write
module i2c_reg_target #(
    parameter logic [6:0] I2C_ADDR   = 7'h70,
    parameter int         NREGS      = 16,
    parameter int         FILTER_LEN = 3,
    parameter logic [7:0] RESET_VAL  = 8'h00,
    localparam int        AW         = (NREGS > 2) ? $clog2(NREGS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    i2c_reg_target_if.slave      bus,
    output logic [NREGS*8-1:0]   regs_o,
    output logic                 wr_strobe,
    output logic [AW-1:0]        wr_index,
    output logic                 busy,
    output logic                 selected
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    // index 0 = SCL, index 1 = SDA
    logic [1:0]    sync1, sync2, filt, filt_q;
    logic [FW-1:0] fcnt [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 2'b11;
            sync2   <= 2'b11;
            filt    <= 2'b11;
            filt_q  <= 2'b11;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            sync1  <= {bus.sda_i, bus.scl_i};
            sync2  <= sync1;
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FW'(1);
                end
            end
        end
    end

    logic scl, sda, scl_rise, scl_fall, start_c, stop_c;
    assign scl      = filt[0];
    assign sda      = filt[1];
    assign scl_rise = scl & ~filt_q[0];
    assign scl_fall = ~scl & filt_q[0];
    assign start_c  = scl & filt_q[0] & filt_q[1] & ~sda;
    assign stop_c   = scl & filt_q[0] & ~filt_q[1] & sda;

    state_t        state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift;
    logic [AW-1:0] ptr;
    logic          rw;
    logic          nak;

    logic [7:0]    rd_byte;
    logic [AW-1:0] ptr_next;
    assign rd_byte  = regs_o[{ptr, 3'b000} +: 8];
    // wrap on NREGS-1 explicitly so non-power-of-2 banks never index past the end
    assign ptr_next = (ptr == AW'(NREGS - 1)) ? '0 : ptr + AW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            ptr        <= '0;
            rw         <= 1'b0;
            nak        <= 1'b0;
            bus.sda_oe <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_index   <= '0;
            busy       <= 1'b0;
            selected   <= 1'b0;
            regs_o     <= {NREGS{RESET_VAL}};
        end else begin
            wr_strobe <= 1'b0;
            if (stop_c) begin
                state      <= IDLE;
                busy       <= 1'b0;
                selected   <= 1'b0;
                bus.sda_oe <= 1'b0;
                bit_cnt    <= '0;
            end else if (start_c) begin
                state      <= ADDR;
                busy       <= 1'b1;
                selected   <= 1'b0;
                bus.sda_oe <= 1'b0;
                bit_cnt    <= '0;
            end else begin
                case (state)
                    ADDR, SUB, WDATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shift   <= {shift[6:0], sda};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (state == ADDR) begin
                                if (shift[7:1] == I2C_ADDR) begin
                                    state      <= ADDR_ACK;
                                    bus.sda_oe <= 1'b1;
                                    selected   <= 1'b1;
                                    rw         <= shift[0];
                                end else begin
                                    state <= IGNORE;
                                end
                            end else if (state == SUB) begin
                                if (32'(shift) < NREGS) begin
                                    ptr        <= shift[AW-1:0];
                                    state      <= SUB_ACK;
                                    bus.sda_oe <= 1'b1;
                                end else begin
                                    state <= IGNORE;
                                end
                            end else begin
                                regs_o[{ptr, 3'b000} +: 8] <= shift;
                                wr_strobe  <= 1'b1;
                                wr_index   <= ptr;
                                ptr        <= ptr_next;
                                state      <= WDATA_ACK;
                                bus.sda_oe <= 1'b1;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                shift      <= {rd_byte[6:0], 1'b0};
                                bus.sda_oe <= ~rd_byte[7];
                                ptr        <= ptr_next;
                                state      <= RDATA;
                            end else begin
                                bus.sda_oe <= 1'b0;
                                state      <= SUB;
                            end
                        end
                    end
                    SUB_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            bus.sda_oe <= 1'b0;
                            state      <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt    <= '0;
                                bus.sda_oe <= 1'b0;
                                state      <= RDATA_ACK;
                            end else begin
                                bus.sda_oe <= ~shift[7];
                                shift      <= {shift[6:0], 1'b0};
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            nak <= sda;
                        end else if (scl_fall) begin
                            if (!nak) begin
                                shift      <= {rd_byte[6:0], 1'b0};
                                bus.sda_oe <= ~rd_byte[7];
                                ptr        <= ptr_next;
                                state      <= RDATA;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    default: bus.sda_oe <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_target.sv
// tb/tb_i2c_reg_target.sv - directed bench for i2c_reg_target
module tb_i2c_reg_target;
    localparam int NREGS = 16;
    localparam int P = 12;
    localparam int Q = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_reg_target_if bus ();
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    assign bus.scl_i = m_scl;
    assign bus.sda_i = m_sda & ~bus.sda_oe;

    logic [NREGS*8-1:0] regs_o;
    logic               wr_strobe;
    logic [3:0]         wr_index;
    logic               busy;
    logic               selected;

    i2c_reg_target #(
        .I2C_ADDR(7'h70), .NREGS(NREGS), .FILTER_LEN(3), .RESET_VAL(8'h00)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .regs_o(regs_o), .wr_strobe(wr_strobe),
        .wr_index(wr_index), .busy(busy), .selected(selected)
    );

    int total = 0;
    int bad = 0;
    logic [7:0] exp_regs [NREGS];
    logic [3:0] sq [$];

    always @(negedge clk) if (wr_strobe === 1'b1) sq.push_back(wr_index);

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_start;
        m_sda = 1'b0; wait_cyc(P); m_scl = 1'b0;
    endtask

    task automatic send_rstart;
        wait_cyc(Q); m_sda = 1'b1; wait_cyc(P); m_scl = 1'b1; wait_cyc(P);
        m_sda = 1'b0; wait_cyc(P); m_scl = 1'b0;
    endtask

    task automatic send_stop;
        wait_cyc(Q); m_sda = 1'b0; wait_cyc(P); m_scl = 1'b1; wait_cyc(P);
        m_sda = 1'b1; wait_cyc(P);
    endtask

    task automatic send_bit(input logic b);
        wait_cyc(Q); m_sda = b; wait_cyc(P); m_scl = 1'b1; wait_cyc(P); m_scl = 1'b0;
    endtask

    task automatic ack_slot(output logic ack);
        wait_cyc(Q); m_sda = 1'b1; wait_cyc(P); m_scl = 1'b1; wait_cyc(P / 2);
        ack = ~bus.sda_i; wait_cyc(P / 2); m_scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        ack_slot(ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            wait_cyc(Q); m_sda = 1'b1; wait_cyc(P); m_scl = 1'b1; wait_cyc(P / 2);
            d[i] = bus.sda_i; wait_cyc(P / 2); m_scl = 1'b0;
        end
        send_bit(~mack);
    endtask

    task automatic check_regs(input string tag);
        for (int n = 0; n < NREGS; n++) begin
            total++;
            if (regs_o[n*8 +: 8] !== exp_regs[n]) begin
                bad++;
                $display("FAIL %s reg[%0d]: got %h want %h", tag, n, regs_o[n*8 +: 8], exp_regs[n]);
            end
        end
    endtask

    task automatic test_reset;
        for (int n = 0; n < NREGS; n++) exp_regs[n] = 8'h00;
        wait_cyc(4); rst = 1'b0; wait_cyc(4);
        total++; if (bus.sda_oe !== 1'b0) begin bad++; $display("FAIL reset sda_oe: got %b want 0", bus.sda_oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
        total++; if (selected !== 1'b0) begin bad++; $display("FAIL reset selected: got %b want 0", selected); end
        total++; if (wr_strobe !== 1'b0) begin bad++; $display("FAIL reset wr_strobe: got %b want 0", wr_strobe); end
        total++; if (wr_index !== 4'd0) begin bad++; $display("FAIL reset wr_index: got %0d want 0", wr_index); end
        check_regs("reset");
    endtask

    task automatic test_write;
        logic a0, a1, a2, a3;
        sq.delete();
        send_start;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL write busy after start: got %b want 1", busy); end
        write_byte(8'hE0, a0); write_byte(8'd10, a1); write_byte(8'h55, a2); write_byte(8'h1F, a3);
        total++; if ({a0, a1, a2, a3} !== 4'b1111) begin bad++; $display("FAIL write acks: got %b want 1111", {a0, a1, a2, a3}); end
        total++; if (selected !== 1'b1) begin bad++; $display("FAIL write selected: got %b want 1", selected); end
        send_stop; wait_cyc(10);
        exp_regs[10] = 8'h55; exp_regs[11] = 8'h1F;
        check_regs("write");
        total++; if (sq.size() != 2) begin bad++; $display("FAIL write strobe count: got %0d want 2", sq.size()); end
        else begin
            total++; if (sq[0] !== 4'd10 || sq[1] !== 4'd11) begin bad++; $display("FAIL write wr_index: got %0d,%0d want 10,11", sq[0], sq[1]); end
        end
        total++; if (busy !== 1'b0 || selected !== 1'b0) begin bad++; $display("FAIL write after stop busy/selected: got %b%b want 00", busy, selected); end
    endtask

    task automatic test_wrong_addr;
        logic a0, a1, a2;
        sq.delete();
        send_start;
        write_byte(8'hE2, a0); write_byte(8'd3, a1); write_byte(8'hAA, a2);
        total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL wrong_addr acks: got %b want 000", {a0, a1, a2}); end
        total++; if (selected !== 1'b0) begin bad++; $display("FAIL wrong_addr selected: got %b want 0", selected); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wrong_addr busy: got %b want 1", busy); end
        send_stop; wait_cyc(10);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrong_addr busy after stop: got %b want 0", busy); end
        total++; if (sq.size() != 0) begin bad++; $display("FAIL wrong_addr strobes: got %0d want 0", sq.size()); end
        check_regs("wrong_addr");
    endtask

    task automatic test_read;
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        send_start;
        write_byte(8'hE0, a0); write_byte(8'd10, a1);
        send_rstart;
        write_byte(8'hE1, a2);
        total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL read acks: got %b want 111", {a0, a1, a2}); end
        read_byte(1'b1, d0); read_byte(1'b0, d1);
        total++; if (d0 !== 8'h55) begin bad++; $display("FAIL read byte0: got %h want 55", d0); end
        total++; if (d1 !== 8'h1F) begin bad++; $display("FAIL read byte1: got %h want 1f", d1); end
        wait_cyc(P);
        total++; if (bus.sda_oe !== 1'b0) begin bad++; $display("FAIL read sda_oe after nak: got %b want 0", bus.sda_oe); end
        send_stop; wait_cyc(10);
    endtask

    task automatic test_wrap;
        logic a0, a1, a2, a3, b0, b1, b2;
        sq.delete();
        send_start;
        write_byte(8'hE0, a0); write_byte(8'd15, a1); write_byte(8'hAA, a2); write_byte(8'hBB, a3);
        send_stop; wait_cyc(10);
        exp_regs[15] = 8'hAA; exp_regs[0] = 8'hBB;
        total++; if ({a0, a1, a2, a3} !== 4'b1111) begin bad++; $display("FAIL wrap acks: got %b want 1111", {a0, a1, a2, a3}); end
        total++; if (sq.size() != 2) begin bad++; $display("FAIL wrap strobe count: got %0d want 2", sq.size()); end
        else begin
            total++; if (sq[0] !== 4'd15 || sq[1] !== 4'd0) begin bad++; $display("FAIL wrap wr_index: got %0d,%0d want 15,0", sq[0], sq[1]); end
        end
        sq.delete();
        send_start;
        write_byte(8'hE0, b0); write_byte(8'd16, b1); write_byte(8'h77, b2);
        send_stop; wait_cyc(10);
        total++; if ({b0, b1, b2} !== 3'b100) begin bad++; $display("FAIL sub16 acks: got %b want 100", {b0, b1, b2}); end
        total++; if (sq.size() != 0) begin bad++; $display("FAIL sub16 strobes: got %0d want 0", sq.size()); end
        check_regs("wrap");
    endtask

    task automatic glitch_bit(input logic b);
        wait_cyc(Q); m_sda = b; wait_cyc(P); m_scl = 1'b1; wait_cyc(P / 2);
        m_sda = ~b; wait_cyc(1); m_sda = b; wait_cyc(2);
        m_sda = ~b; wait_cyc(2); m_sda = b; wait_cyc(6);
        m_scl = 1'b0; wait_cyc(6);
        m_scl = 1'b1; wait_cyc(1); m_scl = 1'b0; wait_cyc(4);
        m_scl = 1'b1; wait_cyc(2); m_scl = 1'b0;
    endtask

    task automatic test_glitch;
        logic a0, a1, a2;
        logic [7:0] d;
        sq.delete();
        d = 8'h96;
        send_start;
        write_byte(8'hE0, a0); write_byte(8'd5, a1);
        send_bit(d[7]); send_bit(d[6]); send_bit(d[5]);
        glitch_bit(d[4]); glitch_bit(d[3]);
        total++; if (busy !== 1'b1 || selected !== 1'b1) begin bad++; $display("FAIL glitch busy/selected: got %b%b want 11", busy, selected); end
        send_bit(d[2]); send_bit(d[1]); send_bit(d[0]);
        ack_slot(a2);
        total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL glitch acks: got %b want 111", {a0, a1, a2}); end
        send_stop; wait_cyc(10);
        exp_regs[5] = 8'h96;
        total++; if (sq.size() != 1) begin bad++; $display("FAIL glitch strobe count: got %0d want 1", sq.size()); end
        else begin
            total++; if (sq[0] !== 4'd5) begin bad++; $display("FAIL glitch wr_index: got %0d want 5", sq[0]); end
        end
        check_regs("glitch");
    endtask

    task automatic test_persist;
        logic a0, a1, a2, a3, b0, b1, c0;
        logic [7:0] d0, d1;
        send_start;
        write_byte(8'hE0, a0); write_byte(8'd7, a1); write_byte(8'h5A, a2); write_byte(8'hA5, a3);
        send_stop;
        send_start;
        write_byte(8'hE0, b0); write_byte(8'd7, b1);
        send_stop;
        send_start;
        write_byte(8'hE1, c0);
        read_byte(1'b1, d0); read_byte(1'b0, d1);
        send_stop; wait_cyc(10);
        exp_regs[7] = 8'h5A; exp_regs[8] = 8'hA5;
        total++; if ({a0, a1, a2, a3, b0, b1, c0} !== 7'h7F) begin bad++; $display("FAIL persist acks: got %b want 1111111", {a0, a1, a2, a3, b0, b1, c0}); end
        total++; if (d0 !== 8'h5A || d1 !== 8'hA5) begin bad++; $display("FAIL persist read: got %h,%h want 5a,a5", d0, d1); end
    endtask

    task automatic test_reset_mid;
        logic a0, a1, a2, b0, b1, b2;
        logic [7:0] d;
        sq.delete();
        d = 8'h11;
        send_start;
        write_byte(8'hE0, a0); write_byte(8'd2, a1);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        wait_cyc(Q); m_sda = 1'b1; wait_cyc(P); m_scl = 1'b1; wait_cyc(P / 2);
        total++; if (bus.sda_oe !== 1'b1) begin bad++; $display("FAIL reset_mid pre sda_oe: got %b want 1", bus.sda_oe); end
        #2 rst = 1'b1;
        #1;
        total++; if (bus.sda_oe !== 1'b0) begin bad++; $display("FAIL reset_mid sda_oe: got %b want 0", bus.sda_oe); end
        for (int n = 0; n < NREGS; n++) exp_regs[n] = 8'h00;
        check_regs("reset_mid");
        total++; if (busy !== 1'b0 || selected !== 1'b0) begin bad++; $display("FAIL reset_mid busy/selected: got %b%b want 00", busy, selected); end
        wait_cyc(5); rst = 1'b0; wait_cyc(10);
        sq.delete();
        send_start;
        write_byte(8'hE0, b0); write_byte(8'd6, b1); write_byte(8'hC3, b2);
        send_stop; wait_cyc(10);
        exp_regs[6] = 8'hC3;
        total++; if ({a0, a1, b0, b1, b2} !== 5'b11111) begin bad++; $display("FAIL reset_mid acks: got %b want 11111", {a0, a1, b0, b1, b2}); end
        total++; if (sq.size() != 1) begin bad++; $display("FAIL reset_mid strobe count: got %0d want 1", sq.size()); end
        else begin
            total++; if (sq[0] !== 4'd6) begin bad++; $display("FAIL reset_mid wr_index: got %0d want 6", sq[0]); end
        end
        check_regs("recover");
    endtask

    initial begin
        test_reset;
        test_write;
        test_wrong_addr;
        test_read;
        test_wrap;
        test_glitch;
        test_persist;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
